// File: rtl/keycode_event_queue.sv
// keycode_event_queue: debounces a raw HID keycode into press/release events queued in a
// small register FIFO. Optional auto-repeat on vsync frame ticks when KEY_REPEAT_EN is defined.
module keycode_event_queue #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DEPTH           = 8,
    parameter int REPEAT_FRAMES   = 15
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic       vs,
    output logic       cmd_valid,
    output logic [4:0] cmd,
    input  logic       cmd_ready,
    output logic [4:0] held,
    output logic       overflow,
    output logic [7:0] drop_count
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);

    function automatic logic [2:0] map_code(input logic [7:0] k);
        case (k)
            8'h1A:   return 3'd1;
            8'h04:   return 3'd2;
            8'h16:   return 3'd3;
            8'h07:   return 3'd4;
            8'h2C:   return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [4:0] code_onehot(input logic [2:0] c);
        case (c)
            3'd1:    return 5'b00001;
            3'd2:    return 5'b00010;
            3'd3:    return 5'b00100;
            3'd4:    return 5'b01000;
            3'd5:    return 5'b10000;
            default: return 5'b00000;
        endcase
    endfunction

    logic [7:0]    key_q;
    logic [CW-1:0] cnt;
    logic [7:0]    cur;
    logic          pend_valid;
    logic [2:0]    pend_code;
    logic          accept;
    logic [2:0]    old_code;
    logic [2:0]    new_code;
    logic          rep_fire;
    logic          push;
    logic [4:0]    push_data;

    assign old_code = map_code(cur);
    assign new_code = map_code(key_q);
    assign accept   = (cnt == CNT_MAX) && (key_q != cur);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            key_q      <= 8'h00;
            cnt        <= '0;
            cur        <= 8'h00;
            held       <= 5'b00000;
            pend_valid <= 1'b0;
            pend_code  <= 3'd0;
        end else begin
            key_q <= keycode;
            if (keycode != key_q) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
            // A press that follows a release on the same update waits one cycle here.
            pend_valid <= accept && (old_code != 3'd0) && (new_code != 3'd0);
            if (accept) begin
                cur       <= key_q;
                held      <= code_onehot(new_code);
                pend_code <= new_code;
            end
        end
    end

`ifdef KEY_REPEAT_EN
    localparam int FW = $clog2(REPEAT_FRAMES + 1);
    logic          vs_q;
    logic          tick;
    logic [FW-1:0] frame_cnt;

    assign tick     = vs & ~vs_q;
    assign rep_fire = tick && !accept && (old_code != 3'd0) &&
                      (frame_cnt == FW'(REPEAT_FRAMES - 1));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            vs_q      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            vs_q <= vs;
            if (accept || (old_code == 3'd0) || rep_fire) begin
                frame_cnt <= '0;
            end else if (tick) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_repeat;
    assign rep_fire      = 1'b0;
    assign unused_repeat = vs ^ REPEAT_FRAMES[0];
`endif

    // Release/press from a key change win over a pending press, which wins over repeat.
    always_comb begin
        push      = 1'b0;
        push_data = 5'd0;
        if (accept && (old_code != 3'd0)) begin
            push      = 1'b1;
            push_data = {2'b01, old_code};
        end else if (accept && (new_code != 3'd0)) begin
            push      = 1'b1;
            push_data = {2'b00, new_code};
        end else if (pend_valid) begin
            push      = 1'b1;
            push_data = {2'b00, pend_code};
        end else if (rep_fire) begin
            push      = 1'b1;
            push_data = {2'b10, old_code};
        end
    end

    // cmd_valid/cmd_ready: the head entry transfers on any Clk edge where both are high;
    // cmd always holds the head entry while cmd_valid is high.
    logic [4:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_next;
    logic [AW:0]   count;
    logic [AW:0]   count_after_pop;
    logic          pop;
    logic          push_ok;
    logic          drop;

    assign cmd_valid       = (count != '0);
    assign pop             = cmd_valid && cmd_ready;
    assign push_ok         = push && ((count != FULL_COUNT) || pop);
    assign drop            = push && (count == FULL_COUNT) && !pop;
    assign count_after_pop = count - (AW+1)'(pop);
    assign rd_next         = rd_ptr + AW'(pop);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            cmd        <= 5'd0;
            overflow   <= 1'b0;
            drop_count <= 8'd0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            count <= count_after_pop + (AW+1)'(push_ok);
            // Look ahead to the post-edge head so a pushed entry is visible one cycle later.
            if (count_after_pop == '0) begin
                cmd <= push_ok ? push_data : 5'd0;
            end else begin
                cmd <= mem[rd_next];
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end
endmodule

// File: tb/tb_keycode_event_queue.sv
// tb_keycode_event_queue: drives directed and random keycode traffic and checks the
// event stream, held one-hot and drop statistics against a behavioural model.
module tb_keycode_event_queue;
    localparam int D     = 4;
    localparam int DEPTH = 8;
    localparam int RF    = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] keycode;
    logic       vs;
    logic       cmd_valid;
    logic [4:0] cmd;
    logic       cmd_ready;
    logic [4:0] held;
    logic       overflow;
    logic [7:0] drop_count;

    always #5 clk = ~clk;

    keycode_event_queue #(
        .DEBOUNCE_CYCLES(D),
        .DEPTH(DEPTH),
        .REPEAT_FRAMES(RF)
    ) dut (
        .Clk(clk),
        .Reset(rst),
        .keycode(keycode),
        .vs(vs),
        .cmd_valid(cmd_valid),
        .cmd(cmd),
        .cmd_ready(cmd_ready),
        .held(held),
        .overflow(overflow),
        .drop_count(drop_count)
    );

    logic [4:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: sample history, accepted key, FIFO occupancy, statistics.
    logic [7:0] hist[$];
    logic [7:0] m_cur;
    int         m_count;
    logic       m_ovf;
    int         m_drops;
    logic [4:0] m_held;
    logic       m_next_valid;
    logic [4:0] m_next_ev;
    logic       m_vs_prev;
    int         m_frames;
    bit         model_on   = 1'b0;
    bit         just_reset = 1'b0;
    int         vs_ctr     = 0;

    function automatic int key_code(input logic [7:0] k);
        case (k)
            8'h1A:   return 1;
            8'h04:   return 2;
            8'h16:   return 3;
            8'h07:   return 4;
            8'h2C:   return 5;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor compares post-edge outputs, then the model advances for the coming edge.
    always @(negedge clk) begin
        logic [4:0] ev;
        logic [7:0] v;
        bit         pop_m;
        bit         have_ev;
        bit         accepted;
        bit         all_same;
        int         oldc;
        int         newc;
        if (model_on) begin
            if (just_reset) begin
                check("reset_cmd", {27'd0, cmd}, 32'd0);
                just_reset = 1'b0;
            end
            check("cmd_valid", {31'd0, cmd_valid}, {31'd0, m_count > 0});
            check("held", {27'd0, held}, {27'd0, m_held});
            check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
            check("drop_count", {24'd0, drop_count}, m_drops);
            if (cmd_valid && cmd_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event: got 0x%0h, expected no event at %0t", cmd, $time);
                end else begin
                    ev = exp_q.pop_front();
                    check("event", {27'd0, cmd}, {27'd0, ev});
                end
            end
        end

        if (rst) begin
            hist.delete();
            hist.push_back(8'h00);
            exp_q.delete();
            m_cur        = 8'h00;
            m_count      = 0;
            m_ovf        = 1'b0;
            m_drops      = 0;
            m_held       = 5'd0;
            m_next_valid = 1'b0;
            m_next_ev    = 5'd0;
            m_vs_prev    = 1'b0;
            m_frames     = 0;
            model_on     = 1'b1;
            just_reset   = 1'b1;
        end else if (model_on) begin
            pop_m    = (m_count > 0) && cmd_ready;
            have_ev  = 1'b0;
            accepted = 1'b0;
            ev       = 5'd0;
            all_same = (hist.size() >= D);
            foreach (hist[i]) if (hist[i] != hist[0]) all_same = 1'b0;
            v = hist[hist.size()-1];
            if (all_same && v != m_cur) begin
                oldc = key_code(m_cur);
                newc = key_code(v);
                if (oldc != 0) begin
                    have_ev = 1'b1;
                    ev      = {2'b01, 3'(oldc)};
                    if (newc != 0) begin
                        m_next_valid = 1'b1;
                        m_next_ev    = {2'b00, 3'(newc)};
                    end
                end else if (newc != 0) begin
                    have_ev = 1'b1;
                    ev      = {2'b00, 3'(newc)};
                end
                m_cur    = v;
                m_held   = (newc == 0) ? 5'd0 : 5'(1 << (newc - 1));
                m_frames = 0;
                accepted = 1'b1;
            end else if (m_next_valid) begin
                have_ev      = 1'b1;
                ev           = m_next_ev;
                m_next_valid = 1'b0;
            end
`ifdef KEY_REPEAT_EN
            if (!accepted) begin
                if (key_code(m_cur) == 0) begin
                    m_frames = 0;
                end else if (vs && !m_vs_prev) begin
                    m_frames++;
                    if (m_frames == RF) begin
                        m_frames = 0;
                        if (!have_ev) begin
                            have_ev = 1'b1;
                            ev      = {2'b10, 3'(key_code(m_cur))};
                        end
                    end
                end
            end
`endif
            m_vs_prev = vs;
            hist.push_back(keycode);
            if (hist.size() > D) void'(hist.pop_front());
            if (pop_m) m_count--;
            if (have_ev) begin
                if (m_count < DEPTH) begin
                    m_count++;
                    exp_q.push_back(ev);
                end else begin
                    m_ovf = 1'b1;
                    if (m_drops < 255) m_drops++;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
        vs_ctr++;
        vs = ((vs_ctr / 4) % 2) == 1;
    endtask

    task automatic drive(input logic [7:0] k, input int n);
        keycode = k;
        repeat (n) cyc();
    endtask

    logic [7:0] keys[7];

    initial begin
        keys = '{8'h00, 8'h1A, 8'h04, 8'h16, 8'h07, 8'h2C, 8'h33};
        rst       = 1'b1;
        keycode   = 8'h00;
        cmd_ready = 1'b0;
        vs        = 1'b0;
        repeat (3) cyc();
        rst       = 1'b0;
        cmd_ready = 1'b1;

        drive(8'h1A, 8);
        drive(8'h00, 8);
        for (int i = 0; i < 5; i++) begin
            drive(8'h1A, 2);
            drive(8'h00, 2);
        end
        drive(8'h00, 6);
        drive(8'h04, 8);
        drive(8'h07, 8);
        drive(8'h00, 8);

        cmd_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            drive(keys[i], 6);
            drive(8'h00, 6);
        end
        cmd_ready = 1'b1;
        drive(8'h00, 12);

        drive(8'h2C, 6);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        drive(8'h2C, 10);
        drive(8'h00, 8);

        drive(8'h33, 8);
        drive(8'h1A, 8);
        drive(8'h33, 8);
        drive(8'h00, 8);

        drive(8'h16, 40);
        drive(8'h00, 10);

        cmd_ready = 1'b0;
        for (int i = 0; i < 140; i++) begin
            drive(8'h1A, 5);
            drive(8'h00, 5);
        end
        cmd_ready = 1'b1;
        drive(8'h00, 12);

        for (int i = 0; i < 150; i++) begin
            cmd_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 60) == 0) begin
                rst = 1'b1;
                cyc();
                rst = 1'b0;
            end
            drive(keys[$urandom_range(0, 6)], $urandom_range(1, 8));
        end

        cmd_ready = 1'b1;
        drive(8'h00, 20);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
